// File: rtl/bcd_display_scanner.sv
// Time-multiplexed driver for a signed 3-digit BCD value onto a shared digit bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros in hundreds/tens.
module bcd_display_scanner #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       sign_i,
  input  logic [3:0] d2_i,
  input  logic [3:0] d1_i,
  input  logic [3:0] d0_i,
  output logic [3:0] digit_code_o,
  output logic [3:0] digit_sel_o,
  output logic       blank_o,
  output logic       minus_o,
  output logic       err_o
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned SEL_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [DIG_W-1:0] BCD_MAX  = DIG_W'(9);
  localparam logic [IDX_W-1:0] IDX_TENS = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_HUND = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_SIGN = IDX_W'(3);

  logic             sign_q, sign_d;
  logic [DIG_W-1:0] d2_q, d2_d;
  logic [DIG_W-1:0] d1_q, d1_d;
  logic [DIG_W-1:0] d0_q, d0_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] code_q, code_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             minus_q, minus_d;

  logic [DIG_W-1:0] cur_digit;
  logic             lz_blank;
  logic             any_nonzero;

  // Hold registers, error flag and scan position for the coming edge
  always_comb begin
    sign_d = sign_q;
    d2_d   = d2_q;
    d1_d   = d1_q;
    d0_d   = d0_q;
    if (load_i) begin
      sign_d = sign_i;
      d2_d   = d2_i;
      d1_d   = d1_i;
      d0_d   = d0_i;
    end
    err_d = (d2_d > BCD_MAX) || (d1_d > BCD_MAX) || (d0_d > BCD_MAX);

    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    cur_digit = d0_d;
    case (idx_d)
      IDX_TENS: cur_digit = d1_d;
      IDX_HUND: cur_digit = d2_d;
      default:  cur_digit = d0_d;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = ((idx_d == IDX_HUND) && (d2_d == '0)) ||
               ((idx_d == IDX_TENS) && (d2_d == '0) && (d1_d == '0));
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  assign any_nonzero = |{d2_d, d1_d, d0_d};

  // Display controls for the position/count/hold values after the edge
  always_comb begin
    code_d  = '0;
    sel_d   = '1;
    blank_d = 1'b1;
    minus_d = 1'b0;
    if (cnt_d != '0) begin
      sel_d = ~(SEL_W'(1) << idx_d);
      if (idx_d == IDX_SIGN) begin
        if (sign_d && any_nonzero) begin
          minus_d = 1'b1;
          blank_d = 1'b0;
        end
      end else if (cur_digit > BCD_MAX) begin
        blank_d = 1'b1;
      end else begin
        code_d  = cur_digit;
        blank_d = lz_blank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q  <= 1'b0;
      d2_q    <= '0;
      d1_q    <= '0;
      d0_q    <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      sel_q   <= '1;
      blank_q <= 1'b1;
      minus_q <= 1'b0;
    end else begin
      sign_q  <= sign_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      minus_q <= minus_d;
    end
  end

  assign digit_code_o = code_q;
  assign digit_sel_o  = sel_q;
  assign blank_o      = blank_q;
  assign minus_o      = minus_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner at PRESCALE=4 (one position = 4 clocks).
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_i;
  logic       sign_i;
  logic [3:0] d2_i, d1_i, d0_i;
  logic [3:0] digit_code_o, digit_sel_o;
  logic       blank_o, minus_o, err_o;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  logic [3:0] exp_code  [4];
  logic       exp_blank [4];
  logic       exp_minus [4];
  logic       exp_err;
  logic [3:0] sel_tab   [4];

  bcd_display_scanner #(.PRESCALE(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .sign_i(sign_i),
    .d2_i(d2_i), .d1_i(d1_i), .d0_i(d0_i),
    .digit_code_o(digit_code_o), .digit_sel_o(digit_sel_o),
    .blank_o(blank_o), .minus_o(minus_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog k=%0d", k);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel"},   32'(digit_sel_o),  32'hF);
    check({tag, "_code"},  32'(digit_code_o), 32'h0);
    check({tag, "_blank"}, 32'(blank_o),      32'h1);
    check({tag, "_minus"}, 32'(minus_o),      32'h0);
    check({tag, "_err"},   32'(err_o),        32'h0);
  endtask

  // k counts edges since reset release: count = k%4, position = (k/4)%4
  task automatic check_phase(input string tag);
    int cnt, idx;
    cnt = k % 4;
    idx = (k / 4) % 4;
    check({tag, "_err"}, 32'(err_o), 32'(exp_err));
    if (cnt == 0) begin
      check({tag, "_dead_sel"},   32'(digit_sel_o), 32'hF);
      check({tag, "_dead_blank"}, 32'(blank_o),     32'h1);
    end else begin
      check({tag, "_sel"},   32'(digit_sel_o),  32'(sel_tab[idx]));
      check({tag, "_code"},  32'(digit_code_o), 32'(exp_code[idx]));
      check({tag, "_blank"}, 32'(blank_o),      32'(exp_blank[idx]));
      check({tag, "_minus"}, 32'(minus_o),      32'(exp_minus[idx]));
    end
  endtask

  task automatic run_scan(input string tag, input int n, input bit first_load);
    for (int i = 0; i < n; i++) begin
      load_i = (i == 0) && first_load;
      @(posedge clk);
      #1;
      load_i = 1'b0;
      k++;
      check_phase(tag);
    end
  endtask

  task automatic set_in(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    sign_i = s; d2_i = h; d1_i = t; d0_i = u;
  endtask

  task automatic set_exp(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                         input logic b0, input logic b1, input logic b2, input logic b3,
                         input logic m3, input logic e);
    exp_code[0] = c0; exp_code[1] = c1; exp_code[2] = c2; exp_code[3] = 4'h0;
    exp_blank[0] = b0; exp_blank[1] = b1; exp_blank[2] = b2; exp_blank[3] = b3;
    exp_minus[0] = 1'b0; exp_minus[1] = 1'b0; exp_minus[2] = 1'b0; exp_minus[3] = m3;
    exp_err = e;
  endtask

  initial begin
    sel_tab[0] = 4'b1110; sel_tab[1] = 4'b1101;
    sel_tab[2] = 4'b1011; sel_tab[3] = 4'b0111;
    rst_n  = 1'b0;
    load_i = 1'b0;
    set_in(1'b0, 4'h0, 4'h0, 4'h0);
    #12;
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    k = 0;

    // Positive 123
    set_in(1'b0, 4'h1, 4'h2, 4'h3);
    set_exp(4'h3, 4'h2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scan("p123", 16, 1'b1);

    // Negative 045: leading zero in hundreds
    set_in(1'b1, 4'h0, 4'h4, 4'h5);
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(4'h5, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`else
    set_exp(4'h5, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    run_scan("n045", 16, 1'b1);

    // Negative zero shows no minus
    set_in(1'b1, 4'h0, 4'h0, 4'h0);
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    set_exp(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    run_scan("nzero", 16, 1'b1);

    // Invalid tens digit, then a corrected reload
    set_in(1'b0, 4'h1, 4'hB, 4'h3);
    set_exp(4'h3, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    run_scan("badB", 16, 1'b1);
    set_in(1'b0, 4'h1, 4'h7, 4'h3);
    set_exp(4'h3, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scan("fix7", 10, 1'b1);

    // Asynchronous reset in the middle of the hundreds slot
    check(" pre_reset_sel", 32'(digit_sel_o), 32'(4'b1011));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    @(posedge clk); #1;
    check_reset("held_reset");
    rst_n = 1'b1;
    k = 0;

    // First active slot after release is units; then mid-tens reload
    set_in(1'b0, 4'h1, 4'h2, 4'h3);
    set_exp(4'h3, 4'h2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scan("post_rst", 5, 1'b1);
    set_in(1'b0, 4'h1, 4'h8, 4'h3);
    exp_code[1] = 4'h8;
    run_scan("midload", 11, 1'b1);
    check("period_idx0_sel", 32'(digit_sel_o), 32'hF);
    run_scan("wrap", 1, 1'b0);
    check("wrap_units_sel", 32'(digit_sel_o), 32'(4'b1110));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Time-multiplexed display driver for the signed 3-digit BCD result.
- Captures sign plus hundreds/tens/units BCD digits and scans them one position at a time onto a shared 4-bit digit bus, with one-hot active-low position enables.
- The digit bus feeds the 7-segment decoder directly downstream; this block adds blank and minus controls, which the decoder cannot express itself.

Parameters:
- PRESCALE, 50000, clocks each position is held (including one dead cycle); legal range 2..2^20.
- CNT_W, 20, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load_i  input  1  capture strobe for sign_i/d2_i/d1_i/d0_i
- sign_i  input  1  1 = negative result
- d2_i  input  4  hundreds BCD digit
- d1_i  input  4  tens BCD digit
- d0_i  input  4  units BCD digit
- digit_code_o  output  4  BCD code to the 7-segment decoder
- digit_sel_o  output  4  active-low position enables; bit0 units, bit1 tens, bit2 hundreds, bit3 sign
- blank_o  output  1  1 = drive all segments off for this position
- minus_o  output  1  1 = light only segment g (minus) for this position
- err_o  output  1  1 = a captured digit is not valid BCD (>9)

Behaviour:
- Interface as fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: digit_sel_o=4'b1111, digit_code_o=0, blank_o=1, minus_o=0, err_o=0; hold registers=0, scan index=0, prescaler count=0.
- Capture: on a rising edge with load_i=1, the hold registers take sign_i/d2_i/d1_i/d0_i. load_i is level-sampled, so holding it high re-captures every cycle.
- err_o is registered with the hold registers: err_o=1 iff any captured digit >9.
- State: a scan index (0..3) and a prescaler count (0..PRESCALE-1). All outputs are registered and reflect the index, count and hold values present after each edge.
- count==PRESCALE-1: count wraps to 0 and index advances 0->1->2->3->0.
- count==0 is the dead cycle (anti-ghosting): digit_sel_o=4'b1111 and blank_o=1.
- count 1..PRESCALE-1 drives the active position:
  - index 0..2: digit_code_o = d0/d1/d2 hold value; digit_sel_o clears bit[index]; minus_o=0.
  - index 3 (sign): digit_code_o=0, digit_sel_o=4'b0111.
    - If sign=1 and the digits are not all zero: minus_o=1, blank_o=0.
    - Otherwise: minus_o=0, blank_o=1 (negative zero shows no minus).
- Invalid digit (>9) at its own position: blank_o=1, digit_code_o=0.
- Load mid-scan: the new value is visible on the next edge. Scan timing is unaffected.
- Reset mid-scan: all state returns to reset values immediately (asynchronous).
- Scan restarts at index 0, count 0, on the first edge after rst_n deasserts.
- Full scan period = 4*PRESCALE clocks.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds position is blanked when d2==0.
  - Tens position is blanked when d2==0 and d1==0.
  - Units is never blanked.
  - Minus stays on the sign position.
- Not defined: all three digit positions always display, including leading zeros.

Test Plan (PRESCALE=4):
- Reset, load_i=1 with sign=0, d2=1, d1=2, d0=3 for one cycle, then run 16 cycles:
  - Every count-0 cycle: digit_sel_o=1111, blank_o=1.
  - Active cycles, per position: units sel=1110 code=3; tens sel=1101 code=2; hundreds sel=1011 code=1; sign sel=0111 blank_o=1.
- Load sign=1, d2=0, d1=4, d0=5 -> sign position: minus_o=1, blank_o=0. Without the macro, hundreds code=0, blank_o=0. With LEADING_ZERO_BLANK_EN, hundreds blank_o=1 and tens code=4.
- Load sign=1, digits 000 -> sign position minus_o=0, blank_o=1. Units code=0, blank_o=0.
- Load d1=4'hB -> err_o=1 on the next edge; tens position blank_o=1, code=0. Reload d1=7 -> err_o=0.
- Assert rst_n=0 in the middle of the hundreds slot -> outputs return to reset values in the same cycle, without waiting for a clock edge. After release, the first active position is units.
- Load new digits during the tens slot -> the tens code changes on the next edge with no change to slot timing; period stays 16 cycles.
